sram_puf_vote_reader: RTL
=========================

// Module: sram_puf_vote_reader
// PURPOSE
//  Parametrised SRAM-PUF response reader. It fetches a burst of LEN response words from a fingerprint ROM
//  that stores NUM_COPIES redundant copies of the response, COPY_STRIDE words apart.
//  Each output word is the bitwise majority vote across the copies. A mask flags the bits whose copies disagreed.
//  Words stream out on a valid/ready interface to the key-generation / authentication logic.
// PARAMETERS
//  DATA_W      8   response word width (bits)
//  ADDR_W      6   ROM address width
//  DEPTH       48  ROM words; valid addresses are 0..DEPTH-1
//  NUM_COPIES  3   redundant copies per word (>=1; odd recommended)
//  COPY_STRIDE 16  address distance between consecutive copies
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       pulse; sampled only in IDLE
//  base_addr   in   ADDR_W  address of copy 0 of the first word
//  len         in   ADDR_W  number of words to return (0 allowed)
//  busy        out  1       high from accepted start until done
//  out_data    out  DATA_W  voted response word
//  out_flip    out  DATA_W  1 = copies disagreed on that bit
//  out_valid   out  1       out_data/out_flip valid
//  out_ready   in   1       consumer accepts when out_valid&&out_ready
//  done        out  1       1-cycle pulse at end of burst (normal or rejected)
//  range_err   out  1       1-cycle pulse, coincident with done, when the burst was rejected
// BEHAVIOUR
//  Reset: every output is 0. The FSM returns to IDLE and the counters and bit accumulators clear.
//    A reset asserted mid-burst abandons the burst; no done is produced.
//  FSM states: IDLE -> CHECK -> READ -> ACC -> OUT -> (READ | FIN) -> IDLE.
//  IDLE
//    start=1 latches base_addr and len and sets busy. start is ignored whenever busy=1.
//  CHECK (1 cycle)
//    len==0 -> FIN; no words are output.
//    Range check, computed at ADDR_W+8 bits so it cannot overflow:
//      base_addr+len-1+(NUM_COPIES-1)*COPY_STRIDE >= DEPTH -> FIN with range_err. No ROM reads are issued.
//  READ (NUM_COPIES cycles)
//    Copy k of word i is read at base_addr+i+k*COPY_STRIDE, with re=1, one copy per cycle.
//    ROM latency is 1 cycle, so data for copy k arrives in the following cycle.
//    Per-bit counters of width $clog2(NUM_COPIES+1) increment on each returned 1.
//  ACC (1 cycle)
//    Absorbs the last ROM return, then computes:
//      vote[b] = cnt[b] > NUM_COPIES/2   (an even-count tie votes 0)
//      flip[b] = cnt[b]!=0 && cnt[b]!=NUM_COPIES
//  OUT
//    out_valid=1. out_data and out_flip are registered and held stable until the handshake.
//    out_ready=0 stalls; no ROM reads are issued while stalled.
//    On handshake: counters clear and i increments. Go to READ if i<len, else FIN.
//  FIN (1 cycle): done=1 (plus range_err if rejected), busy drops the same cycle, then IDLE.
//  Latency: start sampled at cycle 0 -> first out_valid at cycle NUM_COPIES+3 (CHECK, READ xN, ACC).
//    Every later word: handshake at cycle t -> next out_valid at t+NUM_COPIES+2.
//  NUM_COPIES=1: out_flip is always 0 and out_data equals the ROM word.
//  Address arithmetic never wraps, because out-of-range bursts are rejected in CHECK.
// STRUCTURE
//  Package puf_pkg:
//    PUF_DATA_W and PUF_DEPTH.
//    PUF_FP[0:PUF_DEPTH-1], the fingerprint table.
//    The FSM state enum.
//    Function maj_bit(cnt, n).
//  Sub-module puf_fingerprint_rom (DATA_W, ADDR_W, DEPTH):
//    Inputs clk, re, addr; output q.
//    q is registered when re=1 and holds when re=0.
//    An out-of-range addr returns 0.
//    Contents come from puf_pkg::PUF_FP.
//  Top module: FSM, word/copy counters, per-bit count array, vote/flip logic, output registers.
// TESTING (default params; PUF_FP[0]=a3,[3]=3b,[16]=2a,[19]=a2,[32]=a3,[35]=3a)
//  1. start, base=0, len=1, out_ready=1:
//       out_valid at cycle 6; out_data=a3, out_flip=89; done 1 cycle after the handshake; busy low after done.
//  2. start, base=3, len=1 -> out_data=3a, out_flip=99.
//  3. base=0, len=4, out_ready held low for 10 cycles on word 0:
//       out_data/out_flip stay stable and no re pulses occur during the stall.
//       Four words are delivered in order, then a single done.
//  4. base=14, len=4 (last address 49>=48):
//       done and range_err pulse together at cycle 2; no out_valid and no re.
//     Separately, len=0: done at cycle 2 with range_err=0.
//  5. A second start while busy is ignored (len unchanged).
//     rst_n pulsed low during READ: all outputs 0 asynchronously; a fresh start then works normally.
//  6. Re-parametrise NUM_COPIES=1 and NUM_COPIES=2:
//       with 1 copy, out_flip=00 and out_data=PUF_FP[base].
//       with 2 copies and copy values a3/2a, out_data=a3&2a=22 and out_flip=89.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg: shared widths, fingerprint table, FSM states and vote helper for the SRAM-PUF reader.
package puf_pkg;
  localparam int PUF_DATA_W = 8;
  localparam int PUF_DEPTH = 48;
  // Three copies of 16 words each, 16 words apart.
  localparam logic [PUF_DATA_W-1:0] PUF_FP [0:PUF_DEPTH-1] = '{
    8'ha3, 8'h5c, 8'h17, 8'h3b, 8'he0, 8'h91, 8'h4f, 8'hc6,
    8'h28, 8'h7d, 8'hb2, 8'h05, 8'h6a, 8'hd9, 8'h33, 8'h8e,
    8'h2a, 8'h5c, 8'h97, 8'ha2, 8'he1, 8'h11, 8'h4f, 8'h46,
    8'h29, 8'hfd, 8'hb0, 8'h85, 8'h6a, 8'h59, 8'h37, 8'h0e,
    8'ha3, 8'h5d, 8'h17, 8'h3a, 8'h60, 8'h91, 8'hcf, 8'hc4,
    8'h28, 8'h7c, 8'hb2, 8'h45, 8'h6b, 8'hd9, 8'h13, 8'h8e
  };
  typedef enum logic [2:0] {IDLE, CHECK, READ, ACC, OUT, FIN} state_t;
  // Strict majority; an even-count tie resolves to 0.
  function automatic logic maj_bit(input int cnt, input int n);
    return cnt > n / 2;
  endfunction
endpackage

// File: rtl/puf_fingerprint_rom.sv
// puf_fingerprint_rom: registered-read fingerprint ROM; q holds when re=0, out-of-range reads return 0.
module puf_fingerprint_rom
  import puf_pkg::*;
#(
  parameter int DATA_W = PUF_DATA_W,
  parameter int ADDR_W = 6,
  parameter int DEPTH = PUF_DEPTH
)(
  input  logic              clk,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk)
    if (re) q <= int'(addr) < DEPTH ? DATA_W'(PUF_FP[addr]) : '0;
endmodule

// File: rtl/sram_puf_vote_reader.sv
// sram_puf_vote_reader: bursts response words out of the fingerprint ROM, majority-voting
// the redundant copies per bit and flagging bits whose copies disagreed.
module sram_puf_vote_reader
  import puf_pkg::*;
#(
  parameter int DATA_W = PUF_DATA_W,
  parameter int ADDR_W = 6,
  parameter int DEPTH = PUF_DEPTH,
  parameter int NUM_COPIES = 3,
  parameter int COPY_STRIDE = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_flip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              range_err
);
  localparam int CW = $clog2(NUM_COPIES + 1);
  localparam int KW = NUM_COPIES > 1 ? $clog2(NUM_COPIES) : 1;
  localparam int XW = ADDR_W + 8;
  state_t state;
  logic [ADDR_W-1:0] base, n_words, idx, addr;
  logic [KW-1:0] copy;
  logic [CW-1:0] cnt [DATA_W];
  logic [CW-1:0] cnt_nx [DATA_W];
  logic [DATA_W-1:0] q, vote, flip;
  logic [XW-1:0] last_addr;
  logic re, acc;
  assign re = state == READ;
  // ROM data lags the read by one cycle: copy k-1 lands while copy k is being requested.
  assign acc = (state == READ && copy != '0) || state == ACC;
  assign addr = ADDR_W'(XW'(base) + XW'(idx) + XW'(copy) * XW'(COPY_STRIDE));
  assign last_addr = XW'(base) + XW'(n_words) - XW'(1) + XW'((NUM_COPIES - 1) * COPY_STRIDE);
  puf_fingerprint_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rom (
    .clk(clk), .re(re), .addr(addr), .q(q)
  );
  always_comb
    for (int b = 0; b < DATA_W; b++) begin
      cnt_nx[b] = cnt[b] + CW'(acc & q[b]);
      vote[b] = maj_bit(int'(cnt_nx[b]), NUM_COPIES);
      flip[b] = cnt_nx[b] != '0 && int'(cnt_nx[b]) != NUM_COPIES;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      n_words <= '0;
      idx <= '0;
      copy <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      range_err <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_flip <= '0;
      for (int b = 0; b < DATA_W; b++) cnt[b] <= '0;
    end else begin
      done <= 1'b0;
      range_err <= 1'b0;
      if (acc) for (int b = 0; b < DATA_W; b++) cnt[b] <= cnt_nx[b];
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          n_words <= len;
          idx <= '0;
          copy <= '0;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (n_words == '0 || last_addr >= XW'(DEPTH)) begin
          done <= 1'b1;
          range_err <= n_words != '0;
          busy <= 1'b0;
          state <= FIN;
        end else state <= READ;
        READ: begin
          copy <= int'(copy) == NUM_COPIES - 1 ? '0 : copy + 1'b1;
          if (int'(copy) == NUM_COPIES - 1) state <= ACC;
        end
        ACC: begin
          out_data <= vote;
          out_flip <= flip;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          idx <= idx + 1'b1;
          for (int b = 0; b < DATA_W; b++) cnt[b] <= '0;
          if (idx + 1'b1 < n_words) state <= READ;
          else begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= FIN;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
